// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 encodings, the
// controller state enum and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRd,
    StStore,
    StResp,
    StErr
  } lsu_state_e;

  // 1 when the request must be answered with an error: illegal funct3,
  // misaligned half/word, or byte address at/above the memory size (limit).
  function automatic logic access_err(input logic        write,
                                      input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input logic [32:0] limit);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (write) begin
      illegal = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
    end else begin
      illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    // funct3[1:0] gives the access size for every legal encoding
    misaligned   = ((funct3[1:0] == 2'd1) && addr[0]) ||
                   ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
    out_of_range = ({1'b0, addr} >= limit);
    return illegal || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/lsu_mem_master_align.sv
// Combinational byte-lane logic for the load/store unit.
//   mem_word   : word read from memory
//   lane       : byte address bits [1:0]
//   funct3     : RISC-V access size/sign
//   wdata      : store data (low byte/half used for SB/SH)
//   load_data  : selected lane, sign- or zero-extended
//   store_word : mem_word with the store byte/half merged into its lane
module lsu_mem_master_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign byte_sh   = {lane, 3'b000};
  assign half_sh   = {lane[1], 4'b0000};
  assign byte_word = mem_word >> byte_sh;
  assign sel_byte  = byte_word[7:0];
  assign sel_half  = lane[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_data = mem_word;
    unique case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = mem_word;
    endcase
  end

  always_comb begin
    store_word = wdata;
    unique case (funct3[1:0])
      2'd0:    store_word = (mem_word & ~(32'h0000_00ff << byte_sh)) |
                            ({24'h0, wdata[7:0]} << byte_sh);
      2'd1:    store_word = (mem_word & ~(32'h0000_ffff << half_sh)) |
                            ({16'h0, wdata[15:0]} << half_sh);
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit master for a word-addressed data memory. Turns RISC-V
// LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses; SB/SH use a
// read-modify-write (read cycle, then write cycle).
//   clk, reset          : clock, synchronous active-high reset
//   req_*               : request handshake from the datapath controller
//   resp_valid/err/rdata: one-cycle completion pulse with load data
//   mem_*               : strobes/address/data to the data memory
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam logic [32:0] AddrLimit = 33'(MEM_DEPTH) << 2;

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] load_data;
  logic [31:0] store_word;

  lsu_mem_master_align u_align (
    .mem_word   (mem_dout),
    .lane       (addr_q[1:0]),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      wbuf_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      wbuf_q   <= wbuf_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next state. rdata is only updated on the edge into RESP/ERR so that
  // resp_rdata changes together with resp_valid and holds in between.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    wbuf_d   = wbuf_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          if (access_err(req_write, req_funct3, req_addr, AddrLimit)) begin
            state_d = StErr;
            rdata_d = '0;
          end else if (!req_write) begin
            state_d = StLoad;
          end else if (req_funct3 == F3_W) begin
            state_d = StStore;
            wbuf_d  = req_wdata;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        rdata_d = load_data;
        state_d = StResp;
      end
      StRmwRd: begin
        wbuf_d  = store_word;
        state_d = StStore;
      end
      StStore: begin
        rdata_d = '0;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    unique case (state_q)
      StIdle:  req_ready = 1'b1;
      StLoad:  mem_read  = 1'b1;
      StRmwRd: mem_read  = 1'b1;
      StStore: mem_write = ~reset;  // no write may land in a reset cycle
      StResp:  resp_valid = 1'b1;
      StErr: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign mem_addr   = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_din    = mem_write ? wbuf_q : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed, table-driven bench for lsu_mem_master with a behavioural
// word-addressed memory (combinational read, posedge write).
module tb_lsu_mem_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  lsu_mem_master #(.MEM_DEPTH(16384)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model; preload port lets the bench seed words between requests.
  logic [31:0] mem [0:16383];
  logic        pre_en;
  logic [13:0] pre_idx;
  logic [31:0] pre_val;

  assign mem_dout = mem_read ? mem[mem_addr[15:2]] : 32'h0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_write) mem[mem_addr[15:2]] <= mem_din;
  end

  int n_vec;
  int n_bad;
  int wr_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and check the bus invariants there.
  task automatic tick();
    @(negedge clk);
    if (mem_write) wr_seen++;
    check("rd_wr_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
    if (!mem_write) check("din_zero_idle", mem_din, 32'h0);
    if (!mem_read && !mem_write) check("addr_zero_idle", mem_addr, 32'h0);
  endtask

  task automatic preload(input logic [13:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  typedef struct {
    logic        pre;      // reseed word 0x100 to 0x8899AABB first
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;  // cycles from accept to resp_valid
    int          exp_nrd;
    int          exp_wr_cyc; // cycle of the write strobe, 0 = none
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic pre, input logic write, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata, input int lat,
                              input int nrd, input int wcyc, input logic [31:0] din);
    vec_t v;
    v.pre = pre; v.write = write; v.funct3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_err = err; v.exp_rdata = rdata; v.exp_lat = lat; v.exp_nrd = nrd;
    v.exp_wr_cyc = wcyc; v.exp_din = din;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int nrd;
    int wcyc;
    logic [31:0] din;
    logic [31:0] exp_addr;
    string tag;
    tag = $sformatf("v%0d", idx);
    exp_addr = {v.addr[31:2], 2'b00};
    if (v.pre) preload(14'h40, 32'h8899_AABB);
    tick();
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_write  = v.write;
    req_funct3 = v.funct3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    tick();
    req_valid = 1'b0;
    lat  = 0;
    nrd  = 0;
    wcyc = 0;
    din  = 32'h0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (mem_read) begin
        nrd++;
        check({tag, "_rd_addr"}, mem_addr, exp_addr);
      end
      if (mem_write) begin
        wcyc = cyc;
        din  = mem_din;
        check({tag, "_wr_addr"}, mem_addr, exp_addr);
      end
      if (cyc > 1) check({tag, "_ready_busy"}, {31'h0, req_ready}, 32'h0);
      if (resp_valid) begin
        lat = cyc;
        break;
      end
      tick();
    end
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_err"}, {31'h0, resp_err}, {31'h0, v.exp_err});
    check({tag, "_rdata"}, resp_rdata, v.exp_rdata);
    check({tag, "_nread"}, nrd, v.exp_nrd);
    check({tag, "_wr_cycle"}, wcyc, v.exp_wr_cyc);
    if (v.exp_wr_cyc != 0) check({tag, "_din"}, din, v.exp_din);
  endtask

  // Reset arrives `stage` cycles into an SB to 0x100 (0 = RMW_RD, 1 = STORE).
  task automatic reset_abort(input int stage);
    int wr0;
    string tag;
    tag = $sformatf("rst_abort%0d", stage);
    preload(14'h40, 32'h1122_3344);
    tick();
    wr0 = wr_seen;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h100;
    req_wdata  = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < stage; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    tick();
    check({tag, "_wr_in_reset"}, {31'h0, mem_write}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check({tag, "_ready_after"}, {31'h0, req_ready}, 32'h1);
    check({tag, "_no_resp"}, {31'h0, resp_valid}, 32'h0);
    tick();
    tick();
    check({tag, "_mem"}, mem[14'h40], 32'h1122_3344);
    check({tag, "_wr_pulses"}, wr_seen - wr0, 0);
  endtask

  initial begin
    int accepts;
    int resps;
    n_vec = 0; n_bad = 0; wr_seen = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_din", mem_din, 32'h0);
    reset = 1'b0;
    preload(14'h3fff, 32'h0);
    preload(14'h41, 32'h0);

    //           pre  wr   f3    addr           wdata          err  rdata          lat rd wc din
    vecs.push_back(mk(1, 0, 3'd0, 32'h103,       32'h0,         0, 32'hFFFF_FF88, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd4, 32'h103,       32'h0,         0, 32'h0000_0088, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd1, 32'h102,       32'h0,         0, 32'hFFFF_8899, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd2, 32'h100,       32'h0,         0, 32'h8899_AABB, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd5, 32'h100,       32'h0,         0, 32'h0000_AABB, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd0, 32'h101,       32'h0,         0, 32'hFFFF_FFAA, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd0, 32'h101,       32'hDEAD_BE12, 0, 32'h0,         3, 1, 2, 32'h8899_12BB));
    vecs.push_back(mk(0, 0, 3'd2, 32'h100,       32'h0,         0, 32'h8899_12BB, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 3'd1, 32'h102,       32'h0000_5566, 0, 32'h0,         3, 1, 2, 32'h5566_AABB));
    vecs.push_back(mk(0, 1, 3'd2, 32'h104,       32'hCAFE_F00D, 0, 32'h0,         2, 0, 1, 32'hCAFE_F00D));
    vecs.push_back(mk(0, 0, 3'd2, 32'h100,       32'h0,         0, 32'h5566_AABB, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd2, 32'h104,       32'h0,         0, 32'hCAFE_F00D, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd2, 32'h102,       32'h1234_5678, 1, 32'h0,         1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd2, 32'h104,       32'h0,         0, 32'hCAFE_F00D, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd1, 32'h001,       32'h0,         1, 32'h0,         1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd3, 32'h100,       32'h0,         1, 32'h0,         1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd2, 32'h0001_0000, 32'h0,         1, 32'h0,         1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd4, 32'h100,       32'h0,         1, 32'h0,         1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0001_0000, 32'h0,         1, 32'h0,         1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 3'd2, 32'h0000_FFFC, 32'h0,         0, 32'h0,         2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd1, 32'h106,       32'hFFFF_A5A5, 0, 32'h0,         3, 1, 2, 32'hA5A5_F00D));
    vecs.push_back(mk(0, 0, 3'd5, 32'h106,       32'h0,         0, 32'h0000_A5A5, 2, 1, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
    check("word_104_final", mem[14'h41], 32'hA5A5_F00D);

    reset_abort(0);
    reset_abort(1);

    // Back-to-back LW with req_valid held: accept every third cycle.
    preload(14'h40, 32'h0BAD_CAFE);
    tick();
    accepts = 0;
    resps   = 0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h100;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("b2b_ready%0d", i), {31'h0, req_ready}, {31'h0, (i % 3) == 0});
      if (req_ready) accepts++;
      if (resp_valid) begin
        resps++;
        check($sformatf("b2b_rdata%0d", i), resp_rdata, 32'h0BAD_CAFE);
      end
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) resps++;
      tick();
    end
    check("b2b_accepts", accepts, 4);
    check("b2b_resps", resps, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
